// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive/transmit blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver sequencing states (prefixed so they cannot collide with the
    // PARITY parameter of the receiver).
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Parity mode encoding, matches the integer PARITY parameter.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    // True when a receiver/transmitter parameter set is usable.
    function automatic bit uart_params_ok(input int divider, input int char_w,
                                          input int parity, input int stop_bits,
                                          input int sync_stages);
        return (divider >= 8) && (char_w >= 5) && (char_w <= 9) &&
               (parity >= 0) && (parity <= 2) &&
               ((stop_bits == 1) || (stop_bits == 2)) && (sync_stages >= 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Down-counting bit-period timer. tick is high while the count
//               is zero; the counter then reloads DIVIDER-1. load_half aligns
//               the next tick to mid-bit, load_full parks a full period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIVIDER = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(DIVIDER);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(DIVIDER / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DIVIDER - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Next count: explicit loads win over the free-running decrement/reload.
    always_comb begin
        cnt_d = cnt_q - c_one;
        if (load_half) begin
            cnt_d = c_half;
        end else if (load_full) begin
            cnt_d = c_full;
        end else if (cnt_q == '0) begin
            cnt_d = c_full;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_framed
// Description : Framed UART receiver: mid-bit sampling, optional parity,
//               1/2 stop bits, false-start/parity/framing/break detection,
//               valid/ready delivery with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed #(
    parameter int DIVIDER     = 4096,
    parameter int CHAR_W      = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock_50M,
    input  logic              n_reset,
    input  logic              uart_rx_pin,
    output logic [CHAR_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              break_det
);
    import uart_pkg::*;

    localparam int                 c_idx_w     = $clog2(CHAR_W + 1);
    localparam parity_t            c_par_mode  = parity_t'(2'(PARITY));
    localparam logic [c_idx_w-1:0] c_last_data = c_idx_w'(CHAR_W - 1);
    localparam logic [c_idx_w-1:0] c_last_stop = c_idx_w'(STOP_BITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    generate
        if (!uart_params_ok(DIVIDER, CHAR_W, PARITY, STOP_BITS, SYNC_STAGES)) begin : g_bad_params
            $error("uart_rx_framed: illegal parameter set");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_t              state_q, state_d;
    logic [c_idx_w-1:0]     idx_q, idx_d;
    logic [CHAR_W-1:0]      shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_acc_q, par_err_acc_d;
    logic                   frame_acc_q, frame_acc_d;
    logic                   stop_low_q, stop_low_d;
    logic [CHAR_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   break_det_q, break_det_d;

    logic w_rxs, w_tick, w_accept, w_load_half, w_load_full;
    logic w_stop_frame, w_stop_low;

    assign w_rxs    = sync_q[SYNC_STAGES-1];
    assign w_accept = rx_valid_q & rx_ready;

    uart_baud_gen #(
        .DIVIDER (DIVIDER)
    ) u_baud (
        .clk       (clock_50M),
        .rst_n     (n_reset),
        .load_half (w_load_half),
        .load_full (w_load_full),
        .tick      (w_tick)
    );

    // Frame sequencing, character assembly and output handshake next-state.
    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], uart_rx_pin};
        state_d       = state_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        par_bit_d     = par_bit_q;
        par_err_acc_d = par_err_acc_q;
        frame_acc_d   = frame_acc_q;
        stop_low_d    = stop_low_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~w_accept;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q & ~w_accept;
        break_det_d   = 1'b0;
        w_load_half   = 1'b0;
        w_load_full   = 1'b0;
        w_stop_frame  = frame_acc_q | ~w_rxs;
        w_stop_low    = stop_low_q & ~w_rxs;

        case (state_q)
            ST_IDLE: begin
                if (!w_rxs) begin
                    state_d     = ST_START;
                    w_load_half = 1'b1;
                end else begin
                    w_load_full = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (!w_rxs) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;   // false start, silently dropped
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    shift_d = {w_rxs, shift_q[CHAR_W-1:1]};
                    if (idx_q == c_last_data) begin
                        idx_d         = '0;
                        par_bit_d     = 1'b0;
                        par_err_acc_d = 1'b0;
                        frame_acc_d   = 1'b0;
                        stop_low_d    = 1'b1;
                        state_d       = (c_par_mode != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + c_idx_one;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    par_bit_d     = w_rxs;
                    par_err_acc_d = ((^shift_q) ^ w_rxs) != (c_par_mode == PAR_ODD);
                    state_d       = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    frame_acc_d = w_stop_frame;
                    stop_low_d  = w_stop_low;
                    if (idx_q == c_last_stop) begin
                        if ((shift_q == '0) && !par_bit_q && w_stop_low) begin
                            break_det_d = 1'b1;
                        end else if (!rx_valid_q || w_accept) begin
                            rx_data_d    = shift_q;
                            parity_err_d = par_err_acc_q;
                            frame_err_d  = w_stop_frame;
                            rx_valid_d   = 1'b1;
                        end else begin
                            overrun_d = 1'b1;   // set wins over a same-cycle clear
                        end
                        state_d = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        idx_d = idx_q + c_idx_one;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; the synchroniser resets to the idle level.
    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            sync_q        <= '1;
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            par_bit_q     <= 1'b0;
            par_err_acc_q <= 1'b0;
            frame_acc_q   <= 1'b0;
            stop_low_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            break_det_q   <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            par_bit_q     <= par_bit_d;
            par_err_acc_q <= par_err_acc_d;
            frame_acc_q   <= frame_acc_d;
            stop_low_q    <= stop_low_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            break_det_q   <= break_det_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_det_q;

endmodule
`default_nettype wire
